// File: rtl/lcd_sequencer_if.sv
// Strobe/done handshake between lcd_sequencer (master) and lcd_controller (slave).
interface lcd_sequencer_if;
   logic       ctl_rs;
   logic [7:0] ctl_data;
   logic       ctl_strobe;
   logic       ctl_done;

   modport master (output ctl_rs, ctl_data, ctl_strobe, input ctl_done);
   modport slave  (input ctl_rs, ctl_data, ctl_strobe, output ctl_done);
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 power-on/init sequencer plus {rs, byte} command FIFO in front of lcd_controller.
// Optional done watchdog enabled by defining LCD_SEQ_TIMEOUT_EN.
module lcd_sequencer #(
   parameter int unsigned PWR_WAIT_CYC   = 750000,
   parameter int unsigned SHORT_WAIT_CYC = 2000,
   parameter int unsigned LONG_WAIT_CYC  = 82000,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYC    = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic            wr_rs,
   input  logic [7:0]      wr_data,
   output logic            full,
   output logic            overflow,
   output logic            init_done,
   output logic            busy,
   output logic            timeout_err,
   lcd_sequencer_if.master ctl
);
   localparam int unsigned MAX_A   = (PWR_WAIT_CYC > LONG_WAIT_CYC) ? PWR_WAIT_CYC : LONG_WAIT_CYC;
   localparam int unsigned MAX_B   = (SHORT_WAIT_CYC > TIMEOUT_CYC) ? SHORT_WAIT_CYC : TIMEOUT_CYC;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int          CW      = $clog2(CNT_MAX + 1);
   localparam int          AW      = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {PWR_WAIT, ISSUE, WAIT_DONE, DELAY, IDLE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          src_fifo;
   logic [7:0]    init_cmd;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [8:0]    head;
   logic          empty, push, pop;

   logic done_seen, to_hit, is_long, more_init, step_done;
   logic issue, load_delay, advance_init, end_init;

   assign head      = mem[rd_ptr];
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign push      = wr_en && !full;
   // Strobe is high exactly in the first WAIT_DONE cycle, so it masks a stale done level.
   assign done_seen = ctl.ctl_done && !ctl.ctl_strobe;
   assign is_long   = !ctl.ctl_rs && (ctl.ctl_data inside {8'h01, 8'h02, 8'h03});
   assign more_init = !src_fifo && (idx != 2'd3);
   assign step_done = ((state == DELAY) && (cnt == '0)) || to_hit;

   always_comb begin
      // NOTE: default first so every path assigns init_cmd and no latch is inferred.
      init_cmd = 8'h28;
      unique case (idx)
         2'd0: init_cmd = 8'h28;
         2'd1: init_cmd = 8'h06;
         2'd2: init_cmd = 8'h0C;
         2'd3: init_cmd = 8'h01;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for all sequential state avoids read/write ordering races.
      if (rst) state <= PWR_WAIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         PWR_WAIT:  if (cnt == CW'(PWR_WAIT_CYC - 1)) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_seen)   state_nxt = DELAY;
                    else if (to_hit) state_nxt = more_init ? ISSUE : IDLE;
         DELAY:     if (cnt == '0)   state_nxt = more_init ? ISSUE : IDLE;
         IDLE:      if (!empty)      state_nxt = ISSUE;
         default:   state_nxt = PWR_WAIT;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      issue        = (state == ISSUE);
      pop          = issue && src_fifo;
      load_delay   = (state == WAIT_DONE) && done_seen;
      advance_init = step_done && more_init;
      end_init     = step_done && !src_fifo && (idx == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         idx            <= '0;
         src_fifo       <= 1'b0;
         init_done      <= 1'b0;
         ctl.ctl_rs     <= 1'b0;
         ctl.ctl_data   <= '0;
         ctl.ctl_strobe <= 1'b0;
      end else begin
         ctl.ctl_strobe <= issue;
         if (issue) begin
            ctl.ctl_rs   <= src_fifo ? head[8] : 1'b0;
            ctl.ctl_data <= src_fifo ? head[7:0] : init_cmd;
         end
         // DELAY lasts exactly N cycles: load N-1, leave on 0.
         if (state == PWR_WAIT)
            cnt <= cnt + CW'(1);
         else if (load_delay)
            cnt <= is_long ? CW'(LONG_WAIT_CYC - 1) : CW'(SHORT_WAIT_CYC - 1);
         else if ((state == DELAY) && (cnt != '0))
            cnt <= cnt - CW'(1);
         if (advance_init) idx <= idx + 2'd1;
         if (end_init) begin
            init_done <= 1'b1;
            src_fifo  <= 1'b1;
         end
      end
   end

`ifdef LCD_SEQ_TIMEOUT_EN
   logic [CW-1:0] to_cnt;

   assign to_hit = (state == WAIT_DONE) && !done_seen && (to_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (issue)                   to_cnt <= '0;
         else if (state == WAIT_DONE) to_cnt <= to_cnt + CW'(1);
         if (to_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // NOTE: the storage array has no reset; count defines validity, so stale words are never read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_rs, wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
         if (wr_en && full) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a controller model whose done rises 3 cycles after each strobe.
module tb_lcd_sequencer;
   localparam int PWR = 20, SHORT = 5, LONG = 12, DEPTH = 4, TMO = 8;

   typedef struct {
      int         cyc;
      logic       rs;
      logic [7:0] data;
   } strobe_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, overflow, init_done, busy, timeout_err;

   lcd_sequencer_if bus ();

   lcd_sequencer #(
      .PWR_WAIT_CYC(PWR), .SHORT_WAIT_CYC(SHORT), .LONG_WAIT_CYC(LONG),
      .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_rs(wr_rs), .wr_data(wr_data),
      .full(full), .overflow(overflow), .init_done(init_done), .busy(busy),
      .timeout_err(timeout_err), .ctl(bus)
   );

   always #5 clk = ~clk;

   int        n_checks = 0;
   int        n_errors = 0;
   int        cyc = 0;
   int        since = 100;
   logic      block_done = 1'b0;
   strobe_t   log_q[$];
   int        busy_fall_q[$];
   int        init_done_cyc = -1;
   int        tmo_cyc = -1;
   logic      prev_init_done = 1'b0, prev_busy = 1'b1, prev_tmo = 1'b0;
   logic [7:0] init_rom [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

   // Cycle n = n-th rising edge after reset release.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   // Controller model and event monitor.
   always @(negedge clk) begin
      if (rst) begin
         since       = 100;
         bus.ctl_done = 1'b1;
      end else begin
         if (bus.ctl_strobe) begin
            log_q.push_back('{cyc: cyc, rs: bus.ctl_rs, data: bus.ctl_data});
            since = 0;
         end else if (since < 100) begin
            since++;
         end
         bus.ctl_done = !block_done && (since >= 3);
         if (init_done && !prev_init_done) init_done_cyc = cyc;
         if (!busy && prev_busy)           busy_fall_q.push_back(cyc);
         if (timeout_err && !prev_tmo)     tmo_cyc = cyc;
      end
      prev_init_done = init_done;
      prev_busy      = busy;
      prev_tmo       = timeout_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int log_cyc(input int i);
      return (i < log_q.size()) ? log_q[i].cyc : -1;
   endfunction

   function automatic logic [8:0] log_word(input int i);
      return (i < log_q.size()) ? {log_q[i].rs, log_q[i].data} : 9'h1FF;
   endfunction

   function automatic int last_fall();
      return (busy_fall_q.size() > 0) ? busy_fall_q[busy_fall_q.size() - 1] : -1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input logic rs, input logic [7:0] data);
      wr_en = 1'b1; wr_rs = rs; wr_data = data;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_strobe"},   bus.ctl_strobe, 0);
      check({tag, "_rs"},       bus.ctl_rs, 0);
      check({tag, "_data"},     bus.ctl_data, 8'h00);
      check({tag, "_init_done"}, init_done, 0);
      check({tag, "_busy"},     busy, 1);
      check({tag, "_full"},     full, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_timeout"},  timeout_err, 0);
   endtask

   // Reset asserted from any state; outputs checked one edge later, released after two edges.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      tick(1);
      check_reset_values(tag);
      log_q.delete();
      busy_fall_q.delete();
      init_done_cyc = -1;
      tmo_cyc       = -1;
      tick(1);
      rst = 1'b0;
   endtask

   // Init strobes at 21, 31, 41, 51; 12-cycle clear delay ends with init_done and busy low at 67.
   task automatic check_init_seq(input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_init%0d_cyc", tag, i), log_cyc(i), PWR + 1 + 10 * i);
         check($sformatf("%s_init%0d_cmd", tag, i), log_word(i), {1'b0, init_rom[i]});
      end
      check({tag, "_init_done_cyc"}, init_done_cyc, 67);
   endtask

   initial begin
      int c0, base;

      // Power-on, one character queued during init.
      apply_reset("reset");
      tick(5);
      push(1'b1, 8'h41);
      tick(80);
      check("init_strobe_count", log_q.size(), 5);
      check_init_seq("t1");
      check("t1_busy_fall_init", (busy_fall_q.size() > 0) ? busy_fall_q[0] : -1, 67);
      check("t1_char_cyc", log_cyc(4), 69);
      check("t1_char_word", log_word(4), {1'b1, 8'h41});
      check("t1_char_idle", last_fall(), 78);

      // Clear followed by a character: long delay, then short delay.
      c0   = cyc;
      base = log_q.size();
      push(1'b0, 8'h01);
      push(1'b1, 8'h42);
      tick(40);
      check("t2_count", log_q.size(), base + 2);
      check("t2_clear_cyc", log_cyc(base), c0 + 3);
      check("t2_clear_word", log_word(base), {1'b0, 8'h01});
      check("t2_char_cyc", log_cyc(base + 1), c0 + 21);
      check("t2_char_word", log_word(base + 1), {1'b1, 8'h42});
      check("t2_idle", last_fall(), c0 + 30);

      // Sequencer stalled in WAIT_DONE while the FIFO fills and overflows.
      block_done = 1'b1;
      push(1'b1, 8'h50);
      tick(6);
      push(1'b1, 8'h61);
      push(1'b1, 8'h62);
      push(1'b0, 8'h14);
      check("t3_full_after3", full, 0);
      push(1'b1, 8'h63);
      check("t3_full_after4", full, 1);
      check("t3_ovf_after4", overflow, 0);
      push(1'b1, 8'h64);
      check("t3_full_after5", full, 1);
      check("t3_ovf_after5", overflow, 1);
      base = log_q.size();
      check("t3_primer_word", log_word(base - 1), {1'b1, 8'h50});
      block_done = 1'b0;
      tick(80);
      check("t3_drain_count", log_q.size(), base + 4);
      check("t3_drain0", log_word(base),     {1'b1, 8'h61});
      check("t3_drain1", log_word(base + 1), {1'b1, 8'h62});
      check("t3_drain2", log_word(base + 2), {1'b0, 8'h14});
      check("t3_drain3", log_word(base + 3), {1'b1, 8'h63});
      check("t3_full_end", full, 0);
      check("t3_ovf_sticky", overflow, 1);

      // Reset during WAIT_DONE with two entries queued: nothing stale survives.
      block_done = 1'b1;
      push(1'b1, 8'h70);
      tick(6);
      push(1'b1, 8'h71);
      push(1'b1, 8'h72);
      check("t4_busy_before", busy, 1);
      block_done = 1'b0;
      apply_reset("midrst");
      tick(80);
      check("t4_strobe_count", log_q.size(), 4);
      check_init_seq("t4");
      check("t4_idle", busy, 0);

      // Controller never answers.
      block_done = 1'b1;
      apply_reset("blkrst");
      tick(40);
`ifdef LCD_SEQ_TIMEOUT_EN
      check("t5_first_cyc", log_cyc(0), 21);
      check("t5_first_word", log_word(0), {1'b0, 8'h28});
      check("t5_timeout_cyc", tmo_cyc, 29);
      check("t5_second_cyc", log_cyc(1), 30);
      check("t5_second_word", log_word(1), {1'b0, 8'h06});
`else
      check("t5_stuck_count", log_q.size(), 1);
      check("t5_first_word", log_word(0), {1'b0, 8'h28});
      check("t5_timeout", timeout_err, 0);
      check("t5_busy", busy, 1);
`endif
      block_done = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
